// File: rtl/cart_rom_ctrl_if.sv
// rtl/cart_rom_ctrl_if.sv - loader and CPU read bus bundle for cart_rom_ctrl
interface cart_rom_ctrl_if;
   // loader side: byte stream that fills the cartridge RAM
   logic        ioctl_download;
   logic        ioctl_isROM;
   logic        ioctl_wr;
   logic [24:0] ioctl_addr;
   logic [7:0]  ioctl_dout;

   // CPU side: one-cycle read request, data returned one cycle later
   logic [15:0] addr;
   logic        SLTSL_n;
   logic        cpu_rd;
   logic [7:0]  d_to_cpu;
   logic        rd_valid;

   modport master (
      output ioctl_download, ioctl_isROM, ioctl_wr, ioctl_addr, ioctl_dout,
      output addr, SLTSL_n, cpu_rd,
      input  d_to_cpu, rd_valid
   );

   modport slave (
      input  ioctl_download, ioctl_isROM, ioctl_wr, ioctl_addr, ioctl_dout,
      input  addr, SLTSL_n, cpu_rd,
      output d_to_cpu, rd_valid
   );
endinterface

// File: rtl/cart_rom_ctrl.sv
// rtl/cart_rom_ctrl.sv - cartridge ROM loader, size/header mapper and CPU read port (option: CART_ROM_MIRROR_EN)
module cart_rom_ctrl (
   input  logic            clk,
   input  logic            reset_n,
   cart_rom_ctrl_if.slave  bus,
   output logic [15:0]     mem_addr,
   output logic            mem_we,
   output logic [7:0]      mem_din,
   input  logic [7:0]      mem_q,
   output logic            ready,
   output logic [15:0]     start_addr,
   output logic [15:0]     rom_last
);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      LOAD   = 2'd1,
      DETECT = 2'd2,
      READY  = 2'd3
   } state_t;

   // size class chosen in the first detect cycle, consumed in the second
   typedef enum logic [1:0] {
      SZ_16K = 2'd0,
      SZ_32K = 2'd1,
      SZ_48K = 2'd2,
      SZ_BIG = 2'd3
   } size_t;

   state_t      state;
   logic        detect_ph;
   size_t       size_cls;
   logic        oversize;
   logic        wr_seen;
   logic [7:0]  header0 [8];
   logic [7:0]  header1 [8];
   logic        rd_valid_q;
   logic        rd_hit_q;

   logic        load_req;
   logic        ld_in_range;
   logic        ld_accept;
   logic        hdr0_hit;
   logic        hdr1_hit;
   logic [15:0] offset;
   logic [15:0] rd_offset;
   logic        rd_hit;
   logic        h0_ab;
   logic        h1_ab;
   logic [15:0] init0;
   size_t       size_next;
   logic [15:0] start_next;

   assign load_req    = bus.ioctl_download & bus.ioctl_isROM;
   assign ld_in_range = (bus.ioctl_addr[24:16] == 9'd0);
   assign ld_accept   = (state == LOAD) & bus.ioctl_wr & ld_in_range;
   assign hdr0_hit    = (bus.ioctl_addr[15:3] == 13'h0000);
   assign hdr1_hit    = (bus.ioctl_addr[15:3] == 13'h0800);

   // CPU offset into the image, wrapping modulo 64K
   assign offset = bus.addr - start_addr;

`ifdef CART_ROM_MIRROR_EN
   // an 8K image repeats across the whole 16K page it is mapped into
   assign rd_offset = ((rom_last <= 16'h1FFF) && (offset < 16'h4000)) ? {3'b000, offset[12:0]} : offset;
`else
   assign rd_offset = offset;
`endif

   assign rd_hit = (state == READY) & bus.cpu_rd & ~bus.SLTSL_n & (rd_offset <= rom_last);

   // "AB" signature and init vector from the captured headers
   assign h0_ab = (header0[0] == 8'h41) && (header0[1] == 8'h42);
   assign h1_ab = (header1[0] == 8'h41) && (header1[1] == 8'h42);
   assign init0 = {header0[3], header0[2]};

   // size classification from the last loaded address and the oversize flag
   always_comb begin
      size_next = SZ_48K;
      if (oversize || (rom_last > 16'hBFFF)) begin
         size_next = SZ_BIG;
      end else if (rom_last <= 16'h3FFF) begin
         size_next = SZ_16K;
      end else if (rom_last <= 16'h7FFF) begin
         size_next = SZ_32K;
      end
   end

   // start address for the classified size; 16K images follow their init vector
   always_comb begin
      start_next = 16'h0000;
      case (size_cls)
         SZ_16K:  start_next = (init0[15:14] == 2'b10) ? 16'h8000 : 16'h4000;
         SZ_32K:  start_next = (!h0_ab && h1_ab) ? 16'h0000 : 16'h4000;
         default: start_next = 16'h0000;
      endcase
   end

   // RAM port mux: loader writes in LOAD, CPU hit reads in READY, otherwise idle at 0
   always_comb begin
      mem_we   = 1'b0;
      mem_addr = 16'h0000;
      mem_din  = 8'h00;
      if (ld_accept) begin
         mem_we   = 1'b1;
         mem_addr = bus.ioctl_addr[15:0];
         mem_din  = bus.ioctl_dout;
      end else if (rd_hit) begin
         mem_addr = rd_offset;
      end
   end

   // read data comes straight from the RAM output in the cycle after a hit
   assign bus.d_to_cpu = rd_hit_q ? mem_q : 8'hFF;
   assign bus.rd_valid = rd_valid_q;

   // main FSM: load capture, two-cycle detect, ready/abort
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state      <= IDLE;
         detect_ph  <= 1'b0;
         size_cls   <= SZ_16K;
         oversize   <= 1'b0;
         wr_seen    <= 1'b0;
         ready      <= 1'b0;
         start_addr <= 16'h4000;
         rom_last   <= 16'h0000;
         for (int i = 0; i < 8; i++) begin
            header0[i] <= 8'h00;
            header1[i] <= 8'h00;
         end
      end else if (load_req && ((state == IDLE) || (state == READY))) begin
         // a new download always starts from a clean slate
         state     <= LOAD;
         ready     <= 1'b0;
         detect_ph <= 1'b0;
         oversize  <= 1'b0;
         wr_seen   <= 1'b0;
         rom_last  <= 16'h0000;
         for (int i = 0; i < 8; i++) begin
            header0[i] <= 8'h00;
            header1[i] <= 8'h00;
         end
      end else begin
         case (state)
            LOAD: begin
               if (bus.ioctl_wr) begin
                  if (ld_in_range) begin
                     rom_last <= bus.ioctl_addr[15:0];
                     wr_seen  <= 1'b1;
                     if (hdr0_hit) begin
                        header0[bus.ioctl_addr[2:0]] <= bus.ioctl_dout;
                     end
                     if (hdr1_hit) begin
                        header1[bus.ioctl_addr[2:0]] <= bus.ioctl_dout;
                     end
                  end else begin
                     oversize <= 1'b1;
                  end
               end
               if (!bus.ioctl_download) begin
                  // a write landing in the same cycle as the falling edge still counts
                  state     <= (wr_seen || ld_accept) ? DETECT : IDLE;
                  detect_ph <= 1'b0;
               end
            end
            DETECT: begin
               if (!detect_ph) begin
                  size_cls  <= size_next;
                  detect_ph <= 1'b1;
               end else begin
                  start_addr <= start_next;
                  detect_ph  <= 1'b0;
                  ready      <= 1'b1;
                  state      <= READY;
               end
            end
            default: begin
            end
         endcase
      end
   end

   // read response pipeline: every request answers exactly one cycle later
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         rd_valid_q <= 1'b0;
         rd_hit_q   <= 1'b0;
      end else begin
         rd_valid_q <= bus.cpu_rd;
         rd_hit_q   <= rd_hit;
      end
   end

endmodule

// File: doc/cart_rom_ctrl.md
CART_ROM_CTRL -- requirements
Module: cart_rom_ctrl

Interface
REQ-001 SHALL have ports: clk  in  1  system clock (all state on rising edge).
REQ-002 SHALL have ports: reset_n  in  1  asynchronous active-low reset.
REQ-003 SHALL have ports: ioctl_download, ioctl_isROM, ioctl_wr  in  1 each  loader control; ioctl_addr  in  25  load byte address; ioctl_dout  in  8  load byte.
REQ-004 SHALL have ports: addr  in  16  CPU address; SLTSL_n  in  1  slot select (active-low); cpu_rd  in  1  one-cycle read request.
REQ-005 SHALL have ports: mem_addr  out  16; mem_we  out  1; mem_din  out  8; mem_q  in  8  (single-port RAM, 1-cycle read latency).
REQ-006 SHALL have ports: d_to_cpu  out  8; rd_valid  out  1; ready  out  1; start_addr  out  16; rom_last  out  16  highest loaded byte address.

Function
REQ-007 SHALL implement states IDLE, LOAD, DETECT, READY.
REQ-008 IDLE/READY -> LOAD when ioctl_download & ioctl_isROM is high; from READY this aborts mapping and ready drops the following cycle.
REQ-009 LOAD: each cycle with ioctl_wr high and ioctl_addr[24:16]==0 SHALL drive mem_we=1, mem_addr=ioctl_addr[15:0], mem_din=ioctl_dout, and set rom_last=ioctl_addr[15:0].
REQ-010 LOAD: writes with ioctl_addr[24:16]!=0 SHALL not write RAM and SHALL set an oversize flag.
REQ-011 LOAD: bytes 0x0000-0x0007 SHALL be captured to header0, bytes 0x4000-0x4007 to header1.
REQ-012 LOAD -> DETECT when ioctl_download falls after at least one accepted write; -> IDLE if none.
REQ-013 DETECT SHALL take exactly 2 cycles (cycle 1 classify size, cycle 2 register start_addr) then enter READY with ready=1.
REQ-014 Mapping: oversize or rom_last>0xBFFF -> 0x0000; rom_last<=0x3FFF -> 0x8000 if header0 init word {h[3],h[2]} in 0x8000-0xBFFF, else 0x4000.
REQ-015 Mapping: 0x4000<=rom_last<=0x7FFF -> 0x0000 if header0[1:0]!="AB" and header1[1:0]=="AB", else 0x4000; 0x8000<=rom_last<=0xBFFF -> 0x0000.
REQ-016 READY: cpu_rd with SLTSL_n low SHALL compute offset=addr-start_addr (16-bit wrap); hit if offset<=rom_last.
REQ-017 Read hit: mem_addr=offset in request cycle; next cycle rd_valid=1, d_to_cpu=mem_q.
REQ-018 Read miss, SLTSL_n high, or state!=READY: next cycle rd_valid=1, d_to_cpu=0xFF; RAM not accessed.
REQ-019 rd_valid SHALL be a one-cycle pulse exactly one cycle after each cpu_rd; back-to-back cpu_rd every cycle SHALL be supported.
REQ-020 Loader owns the RAM port in LOAD; CPU reads there follow REQ-018.
REQ-021 mem_we SHALL be 0 outside LOAD.

Reset
REQ-022 reset_n low SHALL asynchronously force state=IDLE, ready=0, rd_valid=0, mem_we=0, mem_addr=0, mem_din=0, d_to_cpu=0xFF, start_addr=0x4000, rom_last=0, oversize=0, headers=0.
REQ-023 Reset asserted mid-LOAD SHALL discard the load; after release with download still high the block re-enters LOAD next cycle.

Configuration
REQ-024 Macro CART_ROM_MIRROR_EN defined: when rom_last<=0x1FFF, offset SHALL be masked to offset[12:0] for any offset<0x4000, mirroring 8K ROM across a 16K page.
REQ-025 Macro CART_ROM_MIRROR_EN undefined: no mirroring; REQ-016 applies unmodified.

Verification
REQ-026 Load 16K, header0 "AB",init 0x4010 -> start_addr=0x4000, ready=1 two cycles after download falls; read 0x4000 -> d_to_cpu="A" next cycle.
REQ-027 Load 16K, init 0x8020 -> start_addr=0x8000; read 0x4000 -> 0xFF, read 0x8001 -> "B".
REQ-028 Load 32K, header0 not "AB", header1 "AB" -> start_addr=0x0000; read 0x4001 -> "B".
REQ-029 Load 8K at 0x4000: read 0x6000 -> byte 0x0000 with CART_ROM_MIRROR_EN, 0xFF without.
REQ-030 In READY reassert download; cpu_rd next cycle -> rd_valid with 0xFF, ready=0; reset_n pulse mid-LOAD -> all REQ-022 values immediately.
